// File: rtl/counter_bank.sv
// Bank of NCH independent up/down counters with load, terminal-count pulse and sticky overflow.
// Latency: cnt/tc/ovf/any_tc update on the same edge that samples the controls (1 register stage).
// Backpressure: none; every control input is accepted on every clock edge.
module counter_bank #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NCH    = 4,
    parameter int unsigned MAXVAL = (2 ** WIDTH) - 1,
    parameter int unsigned SAT    = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NCH-1:0]       en_i,
    input  logic [NCH-1:0]       dir_i,
    input  logic [NCH-1:0]       load_i,
    input  logic [NCH*WIDTH-1:0] load_val_i,
    input  logic [NCH-1:0]       clr_ovf_i,
    output logic [NCH*WIDTH-1:0] cnt_o,
    output logic [NCH-1:0]       tc_o,
    output logic [NCH-1:0]       ovf_o,
    output logic                 any_tc_o
);

    // Upper limit and unit step, both held at counter width so no
    // intermediate value ever needs more than WIDTH bits.
    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAXVAL);
    localparam logic [WIDTH-1:0] ZERO_C = '0;
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);
    localparam bit               SAT_C  = (SAT != 0);

    logic [WIDTH-1:0] cnt_q [NCH];
    logic [WIDTH-1:0] cnt_d [NCH];
    logic [NCH-1:0]   tc_q;
    logic [NCH-1:0]   tc_d;
    logic [NCH-1:0]   ovf_q;
    logic [NCH-1:0]   ovf_d;
    logic             any_tc_q;
    logic             any_tc_d;

    // Load values above the limit are clipped to the limit.
    function automatic logic [WIDTH-1:0] clamp_f(input logic [WIDTH-1:0] v);
        return (v > MAX_C) ? MAX_C : v;
    endfunction

    // Per-channel next state: load beats enable, enable beats hold.
    // A step from a limit raises tc and either wraps or sticks at that limit.
    always_comb begin
        tc_d  = '0;
        ovf_d = ovf_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (load_i[i]) begin
                cnt_d[i] = clamp_f(load_val_i[i*WIDTH +: WIDTH]);
            end else if (en_i[i]) begin
                if (dir_i[i]) begin
                    if (cnt_q[i] == MAX_C) begin
                        tc_d[i]  = 1'b1;
                        cnt_d[i] = SAT_C ? MAX_C : ZERO_C;
                    end else begin
                        cnt_d[i] = cnt_q[i] + ONE_C;
                    end
                end else begin
                    if (cnt_q[i] == ZERO_C) begin
                        tc_d[i]  = 1'b1;
                        cnt_d[i] = SAT_C ? ZERO_C : MAX_C;
                    end else begin
                        cnt_d[i] = cnt_q[i] - ONE_C;
                    end
                end
            end
            // A new terminal count takes precedence over a same-edge clear.
            if (tc_d[i]) begin
                ovf_d[i] = 1'b1;
            end else if (clr_ovf_i[i]) begin
                ovf_d[i] = 1'b0;
            end
        end
        any_tc_d = |tc_d;
    end

    // State registers; synchronous active-low reset discards everything.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
            tc_q     <= '0;
            ovf_q    <= '0;
            any_tc_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            tc_q     <= tc_d;
            ovf_q    <= ovf_d;
            any_tc_q <= any_tc_d;
        end
    end

    // Flatten the per-channel counts onto the packed output bus.
    for (genvar g = 0; g < NCH; g++) begin : g_cnt_out
        assign cnt_o[g*WIDTH +: WIDTH] = cnt_q[g];
    end

    assign tc_o     = tc_q;
    assign ovf_o    = ovf_q;
    assign any_tc_o = any_tc_q;

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench: four counter_bank variants driven in parallel against a reference model.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: not applicable; stimulus applied every cycle.
module tb_counter_bank;

    logic        clk;
    logic        rst;
    logic [3:0]  en;
    logic [3:0]  dir;
    logic [3:0]  load;
    logic [31:0] lv;
    logic [3:0]  clr;

    logic [31:0] cnt_w [4];
    logic [3:0]  tc_w  [4];
    logic [3:0]  ovf_w [4];
    logic        any_w [4];

    int n_chk;
    int n_fail;

    // Reference configuration per variant: limit and saturate mode.
    int maxv [4];
    bit satv [4];

    // Reference state.
    int mcnt [4][4];
    bit mtc  [4][4];
    bit movf [4][4];
    bit many [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    counter_bank #(.WIDTH(8), .NCH(4), .MAXVAL(255), .SAT(0)) u_wrap255 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .load_i(load),
        .load_val_i(lv), .clr_ovf_i(clr), .cnt_o(cnt_w[0]), .tc_o(tc_w[0]),
        .ovf_o(ovf_w[0]), .any_tc_o(any_w[0]));

    counter_bank #(.WIDTH(8), .NCH(4), .MAXVAL(9), .SAT(0)) u_wrap9 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .load_i(load),
        .load_val_i(lv), .clr_ovf_i(clr), .cnt_o(cnt_w[1]), .tc_o(tc_w[1]),
        .ovf_o(ovf_w[1]), .any_tc_o(any_w[1]));

    counter_bank #(.WIDTH(8), .NCH(4), .MAXVAL(255), .SAT(1)) u_sat255 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .load_i(load),
        .load_val_i(lv), .clr_ovf_i(clr), .cnt_o(cnt_w[2]), .tc_o(tc_w[2]),
        .ovf_o(ovf_w[2]), .any_tc_o(any_w[2]));

    counter_bank #(.WIDTH(8), .NCH(4), .MAXVAL(200), .SAT(1)) u_sat200 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .load_i(load),
        .load_val_i(lv), .clr_ovf_i(clr), .cnt_o(cnt_w[3]), .tc_o(tc_w[3]),
        .ovf_o(ovf_w[3]), .any_tc_o(any_w[3]));

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: counts are numbers in 0..maxv, stepped modulo maxv+1.
    task automatic model_step();
        for (int d = 0; d < 4; d++) begin
            bit any;
            any = 1'b0;
            for (int c = 0; c < 4; c++) begin
                bit t;
                int m;
                int v;
                t = 1'b0;
                m = maxv[d] + 1;
                v = int'(lv[c*8 +: 8]);
                if (!rst) begin
                    mcnt[d][c] = 0;
                    movf[d][c] = 1'b0;
                end else begin
                    if (load[c]) begin
                        mcnt[d][c] = (v < maxv[d]) ? v : maxv[d];
                    end else if (en[c] && dir[c]) begin
                        t = (mcnt[d][c] == maxv[d]);
                        mcnt[d][c] = (satv[d] && t) ? maxv[d] : (mcnt[d][c] + 1) % m;
                    end else if (en[c]) begin
                        t = (mcnt[d][c] == 0);
                        mcnt[d][c] = (satv[d] && t) ? 0 : (mcnt[d][c] + m - 1) % m;
                    end
                    if (t) movf[d][c] = 1'b1;
                    else if (clr[c]) movf[d][c] = 1'b0;
                end
                mtc[d][c] = t;
                any = any | t;
            end
            many[d] = any;
        end
    endtask

    // One clock: let the edge happen, advance the model, compare everything.
    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("v%0d ch%0d cnt", d, c), int'(cnt_w[d][c*8 +: 8]), mcnt[d][c]);
                check($sformatf("v%0d ch%0d tc", d, c), int'(tc_w[d][c]), int'(mtc[d][c]));
                check($sformatf("v%0d ch%0d ovf", d, c), int'(ovf_w[d][c]), int'(movf[d][c]));
            end
            check($sformatf("v%0d any_tc", d), int'(any_w[d]), int'(many[d]));
        end
    endtask

    function automatic logic [7:0] pick_val();
        logic [7:0] tbl [11];
        tbl = '{8'd0, 8'd1, 8'd8, 8'd9, 8'd10, 8'd199, 8'd200, 8'd201, 8'd254, 8'd255, 8'd127};
        if ($urandom_range(0, 1) == 0) return tbl[$urandom_range(0, 10)];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        n_chk  = 0;
        n_fail = 0;
        maxv   = '{255, 9, 255, 200};
        satv   = '{1'b0, 1'b0, 1'b1, 1'b1};
        rst  = 1'b0;
        en   = 4'hF;
        dir  = 4'hF;
        load = 4'h0;
        lv   = 32'h0;
        clr  = 4'h0;

        // Reset held two cycles with all channels enabled.
        cyc();
        cyc();
        for (int d = 0; d < 4; d++) begin
            check($sformatf("reset v%0d cnt", d), int'(cnt_w[d]), 0);
            check($sformatf("reset v%0d tc", d), int'(tc_w[d]), 0);
            check($sformatf("reset v%0d ovf", d), int'(ovf_w[d]), 0);
            check($sformatf("reset v%0d any", d), int'(any_w[d]), 0);
        end
        rst = 1'b1;
        en  = 4'h0;

        // Wrap upward from 254 on channel 0.
        load = 4'b0001; lv = 32'd254;
        cyc();
        load = 4'b0000; en = 4'b0001; dir = 4'b0001;
        cyc();
        check("wrap 255", int'(cnt_w[0][7:0]), 255);
        check("wrap tc before", int'(tc_w[0][0]), 0);
        cyc();
        check("wrap to 0", int'(cnt_w[0][7:0]), 0);
        check("wrap tc", int'(tc_w[0][0]), 1);
        check("wrap ovf", int'(ovf_w[0][0]), 1);
        check("wrap any", int'(any_w[0]), 1);
        cyc();
        check("wrap to 1", int'(cnt_w[0][7:0]), 1);
        check("wrap tc single", int'(tc_w[0][0]), 0);

        // Downward wrap with a limit of 9 on channel 1.
        en = 4'b0000; load = 4'b0010; lv = 32'h0000_0100;
        cyc();
        load = 4'b0000; en = 4'b0010; dir = 4'b0000;
        cyc();
        check("down 0", int'(cnt_w[1][15:8]), 0);
        cyc();
        check("down 9", int'(cnt_w[1][15:8]), 9);
        check("down tc", int'(tc_w[1][1]), 1);
        cyc();
        check("down 8", int'(cnt_w[1][15:8]), 8);
        check("down tc off", int'(tc_w[1][1]), 0);

        // Saturation at 255 on channel 2.
        en = 4'b0000; load = 4'b0100; lv = 32'h00FF_0000;
        cyc();
        load = 4'b0000; en = 4'b0100; dir = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("sat hold", int'(cnt_w[2][23:16]), 255);
            check("sat tc", int'(tc_w[2][2]), 1);
        end
        dir = 4'b0000;
        cyc();
        check("sat down", int'(cnt_w[2][23:16]), 254);
        check("sat down tc", int'(tc_w[2][2]), 0);

        // Load beats enable, load value clipped to a limit of 200.
        load = 4'b1000; en = 4'b1000; dir = 4'b1000; lv = 32'hFA00_0000;
        cyc();
        check("prio clamp", int'(cnt_w[3][31:24]), 200);
        check("prio tc", int'(tc_w[3][3]), 0);
        load = 4'b0000; clr = 4'b1000;
        cyc();
        check("set beats clr", int'(ovf_w[3][3]), 1);
        check("set beats clr tc", int'(tc_w[3][3]), 1);
        clr = 4'b0000; en = 4'b0000;

        // Reset in the middle of counting on channel 0.
        load = 4'b0001; lv = 32'h7F;
        cyc();
        load = 4'b0000; en = 4'b0001; dir = 4'b0001;
        cyc();
        check("mid count", int'(cnt_w[0][7:0]), 128);
        rst = 1'b0;
        cyc();
        check("mid rst cnt", int'(cnt_w[0][7:0]), 0);
        check("mid rst ovf", int'(ovf_w[0][0]), 0);
        rst = 1'b1;
        cyc();
        check("resume", int'(cnt_w[0][7:0]), 1);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) != 0);
            en  = 4'($urandom);
            dir = 4'($urandom);
            for (int c = 0; c < 4; c++) begin
                load[c]      = ($urandom_range(0, 7) == 0);
                clr[c]       = ($urandom_range(0, 5) == 0);
                lv[c*8 +: 8] = pick_val();
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
